// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder giving an SPI master read/write access to a
// 2^ADDR_WIDTH x 8 register bank. All SPI pins are oversampled in the clk
// domain; sclk edges become clk-domain enables.
// Optional macro SPI_REG_WR_PROTECT_EN: bank[0][0] locks writes to every
// other address; dropped writes flag frame_err at frame end.
module spi_reg_slave #(
    parameter int ADDR_WIDTH  = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    output logic [7:0]            core_rdata,
    output logic                  wr_pulse,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int   DEPTH          = 1 << ADDR_WIDTH;
    localparam logic IDLE_LVL       = (CPOL != 0);
    localparam logic SAMPLE_ON_RISE = ((CPOL != 0) == (CPHA != 0));

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, armed_q, armed_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   rise, fall, sample_en, shift_en;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d, addr_inc;
    logic                   wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   done_q, done_d, err_q, err_d;
    logic                   byte_done, bank_we;
    logic [7:0]             rx_byte;
    logic [7:0]             bank_q [DEPTH];
`ifdef SPI_REG_WR_PROTECT_EN
    logic                   drop_q, drop_d;
`endif

    // Synchronizers; cs_n chain resets low so a frame in flight at reset
    // release is not mistaken for a new frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= IDLE_LVL;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= cs_s ? IDLE_LVL : sclk_s;
            armed_q     <= armed_d;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign armed_d   = armed_q | cs_s;
    assign rise      = sclk_s & ~sclk_prev_q;
    assign fall      = ~sclk_s & sclk_prev_q;
    assign sample_en = SAMPLE_ON_RISE ? rise : fall;
    assign shift_en  = SAMPLE_ON_RISE ? fall : rise;
    assign rx_byte   = {rx_q, mosi_s};
    assign addr_inc  = addr_q + ADDR_WIDTH'(1);

    // FSM state and frame datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            addr_q     <= '0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SPI_REG_WR_PROTECT_EN
            drop_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef SPI_REG_WR_PROTECT_EN
            drop_q     <= drop_d;
`endif
        end
    end

    // Next-state: bit counting, command decode, bank access, frame end.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        bank_we    = 1'b0;
        byte_done  = 1'b0;
`ifdef SPI_REG_WR_PROTECT_EN
        drop_d     = drop_q;
`endif
        if (state_q != IDLE && sample_en) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            byte_done = (bit_cnt_q == 3'd7);
        end
        // Holding the MSB on the edge right after a reload keeps CPHA 0/1 alike.
        if (state_q == RD && shift_en && bit_cnt_q != 3'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
`ifdef SPI_REG_WR_PROTECT_EN
                drop_d = 1'b0;
`endif
                if (!cs_s && armed_q) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (byte_done) begin
                    addr_d = rx_byte[ADDR_WIDTH-1:0];
                    if (rx_byte[7]) begin
                        state_d = RD;
                        tx_d    = bank_q[rx_byte[ADDR_WIDTH-1:0]];
                    end else begin
                        state_d = WR;
                    end
                end
            end
            WR: begin
                if (byte_done) begin
                    addr_d = addr_inc;
`ifdef SPI_REG_WR_PROTECT_EN
                    if (bank_q[0][0] && addr_q != '0) begin
                        drop_d = 1'b1;
                    end else begin
                        bank_we    = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = rx_byte;
                    end
`else
                    bank_we    = 1'b1;
                    wr_pulse_d = 1'b1;
                    wr_addr_d  = addr_q;
                    wr_data_d  = rx_byte;
`endif
                end
            end
            RD: begin
                if (byte_done) begin
                    addr_d = addr_inc;
                    tx_d   = bank_q[addr_inc];
                end
            end
            default: state_d = IDLE;
        endcase
        // A byte completing on the same cycle as cs_n rising is not partial.
        if (cs_s && state_q != IDLE) begin
            done_d = 1'b1;
`ifdef SPI_REG_WR_PROTECT_EN
            err_d  = (bit_cnt_d != 3'd0) | drop_d;
`else
            err_d  = (bit_cnt_d != 3'd0);
`endif
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
    end

    // Register bank: SPI write port, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we) begin
            bank_q[addr_q] <= rx_byte;
        end
    end

    assign miso       = (state_q == RD && !cs_s) ? tx_q[7] : 1'b0;
    assign core_rdata = bank_q[core_addr];
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: one instance per CPOL/CPHA mode
// (index m = CPOL*2 + CPHA), clk/sclk = 10.
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sclk = 4'b1100;
    logic [3:0] cs_n = 4'hF;
    logic [3:0] mosi = 4'h0;
    logic [3:0] core_addr = 4'h0;
    wire  [3:0] miso, wr_pulse, frame_done, frame_err;
    wire  [3:0] wr_addr [4];
    wire  [7:0] wr_data [4];
    wire  [7:0] core_rdata [4];

    int wr_cnt [4] = '{default: 0};
    int done_cnt [4] = '{default: 0};
    int err_cnt [4] = '{default: 0};
    logic [3:0] log_a [$];
    logic [7:0] log_d [$];

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_slave #(
            .ADDR_WIDTH (4),
            .CPOL       (g / 2),
            .CPHA       (g % 2),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .sclk      (sclk[g]),
            .cs_n      (cs_n[g]),
            .mosi      (mosi[g]),
            .miso      (miso[g]),
            .core_addr (core_addr),
            .core_rdata(core_rdata[g]),
            .wr_pulse  (wr_pulse[g]),
            .wr_addr   (wr_addr[g]),
            .wr_data   (wr_data[g]),
            .frame_done(frame_done[g]),
            .frame_err (frame_err[g])
        );
    end

    // Pulse monitor sampled on the falling clk edge.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_pulse[k])   wr_cnt[k]   <= wr_cnt[k] + 1;
            if (frame_done[k]) done_cnt[k] <= done_cnt[k] + 1;
            if (frame_err[k])  err_cnt[k]  <= err_cnt[k] + 1;
        end
        if (wr_pulse[0]) begin
            log_a.push_back(wr_addr[0]);
            log_d.push_back(wr_data[0]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic rd_check(input int m, input logic [3:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        core_addr = a;
        #1;
        check(tag, core_rdata[m], exp);
    endtask

    // Full bytes tx_buf[0..nbytes-1], then 'tail' bits of tx_buf[nbytes].
    task automatic spi_frame(input int m, input int nbytes, input int tail);
        logic       cpol, cpha;
        logic [7:0] r;
        int         nb, nbits;
        cpol = (m / 2) != 0;
        cpha = (m % 2) != 0;
        nb   = (tail > 0) ? nbytes + 1 : nbytes;
        cs_n[m] = 1'b0;
        half();
        half();
        for (int b = 0; b < nb; b++) begin
            nbits = (b < nbytes) ? 8 : tail;
            r = 8'h00;
            for (int i = 0; i < nbits; i++) begin
                if (!cpha) begin
                    mosi[m] = tx_buf[b][7-i];
                    half();
                    r = {r[6:0], miso[m]};
                    sclk[m] = ~cpol;
                    half();
                    sclk[m] = cpol;
                end else begin
                    half();
                    mosi[m] = tx_buf[b][7-i];
                    sclk[m] = ~cpol;
                    half();
                    r = {r[6:0], miso[m]};
                    sclk[m] = cpol;
                end
            end
            rx_buf[b] = r;
        end
        half();
        cs_n[m] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        check("reset miso", miso[0], 1'b0);
        check("reset wr_pulse", wr_pulse[0], 1'b0);
        check("reset wr_addr", wr_addr[0], 4'h0);
        check("reset wr_data", wr_data[0], 8'h00);
        check("reset frame_done", frame_done[0], 1'b0);
        check("reset frame_err", frame_err[0], 1'b0);
        rd_check(0, 4'd3, 8'h00, "reset bank[3]");

        for (int m = 0; m < 4; m++) begin
            tx_buf[0] = 8'h03; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h5A;
            spi_frame(m, 3, 0);
            check($sformatf("m%0d write wr_cnt", m), wr_cnt[m], 2);
            check($sformatf("m%0d write done_cnt", m), done_cnt[m], 1);
            check($sformatf("m%0d write err_cnt", m), err_cnt[m], 0);
            rd_check(m, 4'd3, 8'hA5, $sformatf("m%0d bank[3]", m));
            rd_check(m, 4'd4, 8'h5A, $sformatf("m%0d bank[4]", m));
            if (m == 0) begin
                check("log size", log_a.size(), 2);
                check("log0 addr", log_a[0], 4'd3);
                check("log0 data", log_d[0], 8'hA5);
                check("log1 addr", log_a[1], 4'd4);
                check("log1 data", log_d[1], 8'h5A);
            end
            tx_buf[0] = 8'h83; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
            spi_frame(m, 3, 0);
            check($sformatf("m%0d read byte1", m), rx_buf[1], 8'hA5);
            check($sformatf("m%0d read byte2", m), rx_buf[2], 8'h5A);
            check($sformatf("m%0d read wr_cnt", m), wr_cnt[m], 2);
            check($sformatf("m%0d read done_cnt", m), done_cnt[m], 2);
            check($sformatf("m%0d read err_cnt", m), err_cnt[m], 0);
        end

        // Address wrap 15 -> 0.
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        spi_frame(0, 3, 0);
        rd_check(0, 4'd15, 8'h11, "wrap bank[15]");
        rd_check(0, 4'd0, 8'h22, "wrap bank[0]");
        check("wrap wr_cnt", wr_cnt[0], 4);
        check("wrap wr_addr", wr_addr[0], 4'd0);
        check("wrap wr_data", wr_data[0], 8'h22);

        // Abort mid-byte.
        tx_buf[0] = 8'h02; tx_buf[1] = 8'hF0;
        spi_frame(0, 1, 4);
        rd_check(0, 4'd2, 8'h00, "abort bank[2]");
        check("abort wr_cnt", wr_cnt[0], 4);
        check("abort done_cnt", done_cnt[0], 4);
        check("abort err_cnt", err_cnt[0], 1);

        // Lock register then a write to address 5.
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h01;
        spi_frame(0, 2, 0);
        rd_check(0, 4'd0, 8'h01, "lock bank[0]");
        tx_buf[0] = 8'h05; tx_buf[1] = 8'h77;
        spi_frame(0, 2, 0);
        check("lock done_cnt", done_cnt[0], 6);
`ifdef SPI_REG_WR_PROTECT_EN
        rd_check(0, 4'd5, 8'h00, "locked bank[5]");
        check("locked wr_cnt", wr_cnt[0], 5);
        check("locked err_cnt", err_cnt[0], 2);
`else
        rd_check(0, 4'd5, 8'h77, "unlocked bank[5]");
        check("unlocked wr_cnt", wr_cnt[0], 6);
        check("unlocked err_cnt", err_cnt[0], 1);
`endif

        // Asynchronous reset clears the bank immediately.
        @(negedge clk);
        core_addr = 4'd3;
        rst_n = 1'b0;
        #1;
        check("rst bank[3]", core_rdata[0], 8'h00);
        check("rst wr_addr", wr_addr[0], 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
